// File: rtl/fifo_flex_pkg.sv
// fifo_flex_pkg
// Shared definitions for the fifo_flex block:
//   clog2      - width helper, taken from the shared clog2.vh include
//   fifo_op_e  - per-cycle operation, encoded as {push, pop}
package fifo_flex_pkg;

`include "clog2.vh"

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_flex_if.sv
// fifo_flex_if
// Push/pop/status bundle of fifo_flex.
//   wr_en, wr_dat        push request and data
//   rd_en                pop request
//   clr_err              clears the sticky error flags
//   rd_dat, rd_valid     read data and its qualifier
//   empty, full, afull, aempty, count   occupancy status
//   overflow, underflow  sticky error flags
// slave  : the FIFO side (drives data out and status)
// master : the user side (drives requests)
interface fifo_flex_if
    import fifo_flex_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) ();
    localparam int CW = clog2(DEPTH + 1);

    logic             wr_en;
    logic [WIDTH-1:0] wr_dat;
    logic             rd_en;
    logic             clr_err;
    logic [WIDTH-1:0] rd_dat;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic             afull;
    logic             aempty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, wr_dat, rd_en, clr_err,
        input  rd_dat, rd_valid, empty, full, afull, aempty, count,
               overflow, underflow
    );

    modport slave (
        input  wr_en, wr_dat, rd_en, clr_err,
        output rd_dat, rd_valid, empty, full, afull, aempty, count,
               overflow, underflow
    );
endinterface

// File: rtl/clog2.vh
// clog2.vh
// Shared ceiling-log2 constant function. It returns the number of bits needed
// to index `value` distinct items, so clog2(1)=0, clog2(5)=3 and clog2(16)=4.
// Counters that must hold 0..N inclusive use clog2(N+1).
`ifndef CLOG2_VH
`define CLOG2_VH
function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
        result = result + 1;
        rem    = rem >> 1;
    end
    return result;
endfunction
`endif

// File: rtl/fifo_ram.sv
// fifo_ram
// DEPTH x WIDTH storage for fifo_flex: one synchronous write port and one
// asynchronous read port.
//   clk          clock
//   we           write enable
//   waddr, wdat  write address / data
//   raddr        read address
//   rdat         read data (combinational from raddr)
module fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdat,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdat
);
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; clearing it would force flops instead of
    // RAM and nothing ever reads an entry before it has been written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
    end

    assign rdat = mem[raddr];
endmodule

// File: rtl/fifo_flex.sv
// fifo_flex
// Synchronous FIFO with arbitrary (non power-of-two) depth, programmable
// almost-full/almost-empty levels, sticky error flags and a choice of
// registered read (FWFT=0) or first-word-fall-through (FWFT=1).
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   bus   fifo_flex_if.slave: push/pop requests, read data, status, errors
module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 32,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2,
    parameter int FWFT       = 0
) (
    input  logic      clk,
    input  logic      rst,
    fifo_flex_if.slave bus
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    localparam logic [AW-1:0] PTR_MAX  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

    // Elaboration-time parameter legality.
    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_flex: DEPTH must be at least 2");
    end
    if (AFULL_LVL < 0 || AFULL_LVL > DEPTH) begin : g_bad_afull
        $error("fifo_flex: AFULL_LVL must lie in 0..DEPTH");
    end
    if (AEMPTY_LVL < 0 || AEMPTY_LVL >= DEPTH) begin : g_bad_aempty
        $error("fifo_flex: AEMPTY_LVL must lie in 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("fifo_flex: FWFT must be 0 or 1");
    end

    // Pointers wrap at DEPTH-1, not at 2^AW, so any depth works.
    function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] ram_rdat;
    logic             push;
    logic             pop;
    fifo_op_e         op;

    // A push into a full FIFO is still legal when a pop frees a slot in the
    // same cycle; the popped word is read before the write lands.
    assign pop  = bus.rd_en && (bus.count != '0);
    assign push = bus.wr_en && ((bus.count != DEPTH_C) || pop);
    assign op   = fifo_op_e'({push, pop});

    always_comb begin
        // NOTE: default assignment first so every path drives count_nxt and
        // no latch is inferred.
        count_nxt = bus.count;
        case (op)
            OP_PUSH: count_nxt = bus.count + 1'b1;
            OP_POP:  count_nxt = bus.count - 1'b1;
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            bus.count <= '0;
        end else begin
            if (push) begin
                wptr <= inc_ptr(wptr);
            end
            if (pop) begin
                rptr <= inc_ptr(rptr);
            end
            bus.count <= count_nxt;
        end
    end

    // Sticky errors: a set condition in the same cycle beats clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            if (bus.wr_en && !push) begin
                bus.overflow <= 1'b1;
            end else if (bus.clr_err) begin
                bus.overflow <= 1'b0;
            end
            if (bus.rd_en && !pop) begin
                bus.underflow <= 1'b1;
            end else if (bus.clr_err) begin
                bus.underflow <= 1'b0;
            end
        end
    end

    // Flags decode the registered count only.
    assign bus.empty  = (bus.count == '0);
    assign bus.full   = (bus.count == DEPTH_C);
    assign bus.afull  = (bus.count >= AFULL_C);
    assign bus.aempty = (bus.count <= AEMPTY_C);

    fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (wptr),
        .wdat  (bus.wr_dat),
        .raddr (rptr),
        .rdat  (ram_rdat)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word is shown directly; a push into an empty FIFO becomes
        // visible once count has registered the push.
        assign bus.rd_dat   = ram_rdat;
        assign bus.rd_valid = !bus.empty;
    end else begin : g_reg_read
        always_ff @(posedge clk) begin
            if (rst) begin
                bus.rd_valid <= 1'b0;
            end else begin
                bus.rd_valid <= pop;
            end
        end

        // Data register is left unreset; rd_valid qualifies it and it holds
        // the last popped word between pops.
        always_ff @(posedge clk) begin
            if (!rst && pop) begin
                bus.rd_dat <= ram_rdat;
            end
        end
    end
endmodule

// File: doc/fifo_flex.md
FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 SHALL take parameter DEPTH, default 16; entry count, any integer >= 2, power of two not required.
REQ-002 SHALL take parameter WIDTH, default 32; data bits per entry.
REQ-003 SHALL take parameter AFULL_LVL, default DEPTH-2; afull asserts at count >= AFULL_LVL.
REQ-004 SHALL take parameter AEMPTY_LVL, default 2; aempty asserts at count <= AEMPTY_LVL.
REQ-005 SHALL take parameter FWFT, default 0; 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL use one clock and a synchronous active-high reset.
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 wr_en  in  1  push request; wr_dat  in  WIDTH  push data.
REQ-010 rd_en  in  1  pop request.
REQ-011 rd_dat  out  WIDTH  read data; rd_valid  out  1  rd_dat holds a popped word (FWFT=0) or the head word (FWFT=1).
REQ-012 empty, full, afull, aempty  out  1 each  status flags.
REQ-013 count  out  clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-014 overflow, underflow  out  1 each  sticky error flags; clr_err  in  1  clears both.

Function
REQ-015 Push accepted iff wr_en && (!full || pop accepted same cycle); accepted word written at wptr.
REQ-016 Pop accepted iff rd_en && !empty; rptr advances.
REQ-017 wptr, rptr SHALL wrap from DEPTH-1 to 0 (modulo DEPTH, not modulo 2^n).
REQ-018 count SHALL be +1 on push only, -1 on pop only, unchanged on both or neither; never exceeds DEPTH or drops below 0.
REQ-019 empty = (count==0), full = (count==DEPTH), afull = (count>=AFULL_LVL), aempty = (count<=AEMPTY_LVL); all decoded from registered count, valid same cycle as count.
REQ-020 FWFT=0: on accepted pop, rd_dat loads head word at next edge, rd_valid=1 for that one cycle; otherwise rd_valid=0, rd_dat holds last value.
REQ-021 FWFT=1: rd_dat = word at rptr, rd_valid = !empty combinationally; pop consumes displayed word, next word visible following cycle.
REQ-022 Push on empty in FWFT=1: word visible (rd_valid=1) the cycle after the push edge; read latency 1 cycle in both modes.
REQ-023 wr_en while full with no accepted pop: write dropped, state unchanged, overflow set at next edge.
REQ-024 rd_en while empty: ignored, underflow set at next edge; simultaneous wr_en on empty still accepted.
REQ-025 clr_err clears overflow/underflow at next edge; set condition in same cycle wins over clr_err.
REQ-026 Push and pop both accepted when full: count stays DEPTH, full stays 1, popped word is old head, not new data.

Reset
REQ-027 rst SHALL set wptr=0, rptr=0, count=0, rd_valid=0, overflow=0, underflow=0 at the next edge, abandoning any in-flight operation.
REQ-028 After reset: empty=1, full=0, aempty=1, afull=(AFULL_LVL==0); rd_dat value undefined, storage array not cleared.
REQ-029 wr_en/rd_en asserted in the reset cycle SHALL be ignored and SHALL NOT set error flags.

Structure
REQ-030 Width function clog2 SHALL come from the shared clog2.vh include; no local copy.
REQ-031 Storage SHALL be sub-module fifo_ram (DEPTH x WIDTH, one write port, one asynchronous read port); pointer, count, flag and read-mode logic in fifo_flex.
REQ-032 Parameter legality (AFULL_LVL<=DEPTH, AEMPTY_LVL<DEPTH, FWFT in {0,1}) SHALL be checked at elaboration.

Verification
REQ-033 DEPTH=5, FWFT=0: push 1..5 -> full=1, count=5; pop 5 times -> rd_dat 1,2,3,4,5 on consecutive cycles with rd_valid=1, then empty=1.
REQ-034 DEPTH=5: 12 interleaved push/pop of 0x10..0x1B -> output order intact across pointer wrap at index 4->0.
REQ-035 DEPTH=5 full, push 0xAA without pop -> overflow=1, count=5, contents unchanged; clr_err -> overflow=0 next cycle.
REQ-036 FWFT=1, empty, push 0x55 -> rd_valid=1 and rd_dat=0x55 next cycle; pop with simultaneous push 0x66 -> rd_dat=0x66, count=1.
REQ-037 DEPTH=16, AFULL_LVL=14, AEMPTY_LVL=2: fill 0->16 -> aempty falls at count 3, afull rises at count 14; drain reverses at same levels.
REQ-038 count=3, assert rst with wr_en=rd_en=1 -> next cycle count=0, empty=1, overflow=underflow=0.
